// File: rtl/stable_stim_gen_pkg.sv
// Shared types and LFSR step function for the stable stimulus generator.
// The LFSR is a 16-bit Galois right-shift register, x^16+x^14+x^13+x^11+1.
package stim_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stable_stim_gen_lfsr.sv
// Galois LFSR state register; load and advance are commanded by the owning FSM.
// A coincident load and advance steps from the loaded value.
module lfsr_galois
    import stim_gen_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] base;

    assign base = load ? load_val : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= LFSR_W'(lfsr_next(16'(base)));
        end else if (load) begin
            state <= load_val;
        end
    end

endmodule

// File: rtl/stable_stim_gen.sv
// Random stimulus driver: emits N LFSR samples, each held H clocks, with
// registered valid/changed flags so downstream $stable/$rose/$fell checkers have a reference.
module stable_stim_gen
    import stim_gen_pkg::*;
#(
    parameter int                WIDTH  = 1,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [CNT_W-1:0]  hold_cycles,
    input  logic              pause,
    output logic [WIDTH-1:0]  a_out,
    output logic              a_valid,
    output logic              a_changed,
    output logic [CNT_W-1:0]  sample_idx,
    output logic              busy,
    output logic              done
);

    state_t state, state_d;

    logic [LFSR_W-1:0] lfsr_q, load_val, base, nxt;
    logic              lfsr_load, lfsr_adv;
    logic              start_run, step, last_sample;

    logic [CNT_W-1:0]  n_lat, h_lat, hold_cnt, h_eff;
    logic [CNT_W-1:0]  n_d, h_d, hold_d, idx_d;
    logic [WIDTH-1:0]  a_out_d;
    logic              a_valid_d, done_d;

    assign load_val    = (seed == '0) ? SEED : seed;
    // Mirrors the sub-module's load-then-advance so a_out sees the same next value.
    assign base        = lfsr_load ? load_val : lfsr_q;
    assign nxt         = LFSR_W'(lfsr_next(16'(base)));
    assign h_eff       = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
    assign last_sample = (sample_idx == n_lat - CNT_W'(1));

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (load_val),
        .adv      (lfsr_adv),
        .state    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start) state_d = (num_samples == '0) ? FIN : RUN;
            RUN:  if (!pause && hold_cnt == '0 && last_sample) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_load = (state == IDLE) && seed_load;
        start_run = (state == IDLE) && start && (num_samples != '0);
        step      = (state == RUN) && !pause && (hold_cnt == '0) && !last_sample;
        lfsr_adv  = start_run || step;
        busy      = (state != IDLE);
    end

    always_comb begin
        a_out_d   = a_out;
        a_valid_d = a_valid;
        idx_d     = sample_idx;
        hold_d    = hold_cnt;
        n_d       = n_lat;
        h_d       = h_lat;
        done_d    = (state_d == FIN);
        if (state == IDLE && start) begin
            n_d = num_samples;
            h_d = h_eff;
        end
        if (start_run) begin
            a_out_d   = nxt[WIDTH-1:0];
            a_valid_d = 1'b1;
            idx_d     = '0;
            hold_d    = h_eff - CNT_W'(1);
        end else if (state == RUN && !pause) begin
            if (hold_cnt != '0) begin
                hold_d = hold_cnt - CNT_W'(1);
            end else if (!last_sample) begin
                a_out_d = nxt[WIDTH-1:0];
                idx_d   = sample_idx + CNT_W'(1);
                hold_d  = h_lat - CNT_W'(1);
            end else begin
                a_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out      <= '0;
            a_valid    <= 1'b0;
            a_changed  <= 1'b0;
            sample_idx <= '0;
            done       <= 1'b0;
            hold_cnt   <= '0;
            n_lat      <= '0;
            h_lat      <= '0;
        end else begin
            a_out      <= a_out_d;
            a_valid    <= a_valid_d;
            a_changed  <= (a_out_d != a_out) && a_valid_d;
            sample_idx <= idx_d;
            done       <= done_d;
            hold_cnt   <= hold_d;
            n_lat      <= n_d;
            h_lat      <= h_d;
        end
    end

endmodule

// File: tb/tb_stable_stim_gen.sv
// Bench for stable_stim_gen: table of run shapes, fixed corner sequences and
// randomized runs, all checked per cycle against a sample-timeline model.
module tb_stable_stim_gen;

    localparam int WIDTH = 1;
    localparam int LFSR_W = 16;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst, start, seed_load, pause;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0]  num_samples, hold_cycles;
    logic [WIDTH-1:0]  a_out;
    logic              a_valid, a_changed, busy, done;
    logic [CNT_W-1:0]  sample_idx;

    always #5 clk = ~clk;

    stable_stim_gen #(.WIDTH(WIDTH), .LFSR_W(LFSR_W), .SEED(16'hACE1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .num_samples(num_samples), .hold_cycles(hold_cycles), .pause(pause),
        .a_out(a_out), .a_valid(a_valid), .a_changed(a_changed),
        .sample_idx(sample_idx), .busy(busy), .done(done)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0]      m_lfsr;
    logic [WIDTH-1:0] m_aout;
    logic [7:0]       m_idx;
    logic             obs_a[$];
    logic             obs_c[$];

    typedef struct {
        bit          sld;
        logic [15:0] sv;
        int          n;
        int          h;
        int          exp_len;
        logic        exp_first;
    } vec_t;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return (s % 2 == 1) ? ((s / 2) ^ 16'hB400) : (s / 2);
    endfunction

    function automatic logic [15:0] mk(input logic a, input logic v, input logic c,
                                       input logic [7:0] idx, input logic b, input logic d);
        return {3'b000, a, v, c, idx, b, d};
    endfunction

    function automatic logic [15:0] outs();
        return {3'b000, a_out, a_valid, a_changed, sample_idx, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; pause = 1'b0;
        seed = '0; num_samples = '0; hold_cycles = '0;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1; m_aout = '0; m_idx = '0;
    endtask

    // Model: a run is a timeline of N*H valid slots plus one FIN slot; pause in RUN holds the slot.
    task automatic do_run(input string tag, input bit sld, input logic [15:0] sv, input int n,
                          input int h, input int pmode, input bit poke,
                          output int busy_len, output int done_cnt, output logic first_a);
        int he, total, ptr, cyc;
        bit p, ev;
        logic ea;
        logic [7:0] eidx;
        logic vals[$];
        he = (h == 0) ? 1 : h;
        total = n * he;
        if (sld) m_lfsr = (sv == 16'h0) ? 16'hACE1 : sv;
        vals = {};
        for (int k = 0; k < n; k++) begin
            m_lfsr = ref_step(m_lfsr);
            vals.push_back(m_lfsr[0]);
        end
        obs_a = {}; obs_c = {};
        busy_len = 0; done_cnt = 0; first_a = 1'b0;
        seed_load = sld; seed = sv; num_samples = 8'(n); hold_cycles = 8'(h); start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        num_samples = 8'($urandom); hold_cycles = 8'($urandom);
        ptr = 0; cyc = 1;
        while (ptr <= total) begin
            if (cyc > 60000) begin
                check({tag, "_timeout"}, 32'(ptr), 32'(total + 1));
                break;
            end
            ev = (ptr < total);
            ea = ev ? vals[ptr / he] : m_aout;
            if (ev) m_idx = 8'(ptr / he);
            eidx = m_idx;
            check($sformatf("%s_c%0d", tag, cyc), 32'(outs()),
                  32'(mk(ea, ev, ev && (ea != m_aout), eidx, 1'b1, ptr == total)));
            m_aout = ea;
            if (ptr == 0) first_a = a_out;
            if (ev) begin obs_a.push_back(a_out); obs_c.push_back(a_changed); end
            busy_len += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
            if (pmode == 1) p = ($urandom_range(0, 3) == 0);
            else if (pmode == 2) p = (cyc >= 3 && cyc < 6);
            else p = 1'b0;
            pause = p;
            start = poke && (cyc == 2);
            if (!(p && ev)) ptr++;
            @(negedge clk);
            cyc++;
        end
        pause = 1'b0; start = 1'b0;
        check({tag, "_idle"}, 32'(outs()), 32'(mk(m_aout, 1'b0, 1'b0, m_idx, 1'b0, 1'b0)));
    endtask

    initial begin
        vec_t vt[7];
        int bl, dc;
        logic fa;
        logic exp_a[6];
        logic exp_c[6];
        vt[0] = '{1'b1, 16'hACE1, 6, 1, 7, 1'b0};
        vt[1] = '{1'b1, 16'hACE1, 3, 4, 13, 1'b0};
        vt[2] = '{1'b1, 16'hACE1, 0, 5, 1, 1'b0};
        vt[3] = '{1'b1, 16'h0000, 1, 1, 2, 1'b0};
        vt[4] = '{1'b1, 16'h0001, 1, 1, 2, 1'b0};
        vt[5] = '{1'b1, 16'hACE1, 2, 0, 3, 1'b0};
        vt[6] = '{1'b1, 16'h0E27, 1, 3, 4, 1'b1};
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        do_reset();
        check("reset_outs", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0)));

        // Scenario 1: exact sample sequence from default seed.
        do_run("s1", 1'b0, 16'h0, 6, 1, 0, 1'b0, bl, dc, fa);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s1_a%0d", i + 1), 32'(obs_a[i]), 32'(exp_a[i]));
            check($sformatf("s1_chg%0d", i + 1), 32'(obs_c[i]), 32'(exp_c[i]));
        end
        check("s1_busy_len", 32'(bl), 32'd7);

        // Scenario 3: N=0 leaves the LFSR alone, so the next run repeats scenario 1.
        do_reset();
        do_run("s3", 1'b0, 16'h0, 0, 3, 0, 1'b0, bl, dc, fa);
        check("s3_done", 32'(dc), 32'd1);
        do_run("s3b", 1'b0, 16'h0, 6, 1, 0, 1'b0, bl, dc, fa);
        for (int i = 0; i < 6; i++) check($sformatf("s3_a%0d", i + 1), 32'(obs_a[i]), 32'(exp_a[i]));

        // Table of run shapes.
        for (int i = 0; i < 7; i++) begin
            do_run($sformatf("t%0d", i), vt[i].sld, vt[i].sv, vt[i].n, vt[i].h, 0, 1'b0, bl, dc, fa);
            check($sformatf("t%0d_len", i), 32'(bl), 32'(vt[i].exp_len));
            check($sformatf("t%0d_done", i), 32'(dc), 32'd1);
            if (vt[i].n != 0) check($sformatf("t%0d_first", i), 32'(fa), 32'(vt[i].exp_first));
        end

        // Scenario 5: pause 3 cycles mid-sample-1 plus a stray start during RUN.
        do_run("s5", 1'b1, 16'h1234, 4, 2, 2, 1'b1, bl, dc, fa);
        check("s5_len", 32'(bl), 32'd12);
        check("s5_done", 32'(dc), 32'd1);

        // Scenario 6: reset in cycle 4 of a run aborts with no done.
        do_reset();
        num_samples = 8'd10; hold_cycles = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s6_abort", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0)));
        rst = 1'b0;
        m_lfsr = 16'hACE1; m_aout = '0; m_idx = '0;
        do_run("s6r", 1'b0, 16'h0, 6, 1, 0, 1'b0, bl, dc, fa);
        for (int i = 0; i < 6; i++) check($sformatf("s6_a%0d", i + 1), 32'(obs_a[i]), 32'(exp_a[i]));

        // Boundaries: maximum sample count and maximum hold.
        do_run("bn", 1'b0, 16'h0, 255, 1, 0, 1'b0, bl, dc, fa);
        check("bn_len", 32'(bl), 32'd256);
        do_run("bh", 1'b0, 16'h0, 2, 255, 1, 1'b0, bl, dc, fa);
        check("bh_done", 32'(dc), 32'd1);

        // Randomized runs against the model.
        for (int r = 0; r < 14; r++) begin
            logic [15:0] rs;
            rs = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            do_run($sformatf("r%0d", r), 1'($urandom_range(0, 1)), rs, $urandom_range(0, 20),
                   $urandom_range(0, 4), 1, 1'($urandom_range(0, 1)), bl, dc, fa);
            check($sformatf("r%0d_done", r), 32'(dc), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stable_stim_gen.md
Name: stable_stim_gen

Overview:
Synthesizable random-stimulus driver for single-clock assertion benches. On a start request it emits a programmable number of pseudo-random samples on a_out. Each sample is held stable for a programmable number of clocks. Per-cycle change/stable status is flagged so $stable/$rose/$fell checkers downstream always have a known-correct reference. This block is the driving end of the stimulus-to-checker interface; the assertion modules sit on the consuming end.

Parameters:
WIDTH, 1, bit width of a_out (taken from LFSR bits [WIDTH-1:0]); legal 1..LFSR_W
LFSR_W, 16, LFSR state width
SEED, 16'hACE1, reset/default LFSR seed; must be nonzero
CNT_W, 8, width of sample-count and hold-count fields

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request a run; sampled only in IDLE
seed_load  in  1  in IDLE, load seed into LFSR (same cycle as start allowed; load applies first)
seed  in  LFSR_W  seed value; 0 is replaced by SEED
num_samples  in  CNT_W  samples per run, latched at start
hold_cycles  in  CNT_W  clocks each sample is held, latched at start; 0 treated as 1
pause  in  1  freeze LFSR, hold counter and outputs while RUN
a_out  out  WIDTH  stimulus value
a_valid  out  1  a_out is a live sample of the current run
a_changed  out  1  a_out differs from its value in the previous cycle (asserted only when a_valid)
sample_idx  out  CNT_W  index of the sample currently on a_out (0-based)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, lfsr=SEED, a_out=0, a_valid=0, a_changed=0, sample_idx=0, done=0. Reset mid-run aborts immediately. No done pulse is issued for an aborted run.
- LFSR: Galois, right shift. If lfsr[0]=1: next=(lfsr>>1)^16'hB400; else next=lfsr>>1. Polynomial x^16+x^14+x^13+x^11+1. The LFSR advances once per new sample only.
- States: IDLE, RUN, FIN.
- IDLE:
  - seed_load=1: lfsr <= (seed==0 ? SEED : seed).
  - start=1: latch N=num_samples and H=max(hold_cycles,1).
  - If N==0: go to FIN. a_valid stays 0.
  - Otherwise: lfsr <= next(lfsr), a_out <= next[WIDTH-1:0], a_valid<=1, sample_idx<=0, hold_cnt<=H-1, go to RUN.
  - When start and seed_load coincide, the advance uses the loaded seed.
- RUN, per edge with pause=0:
  - hold_cnt>0: decrement; a_out unchanged.
  - hold_cnt==0 and sample_idx<N-1: advance LFSR, new a_out, sample_idx++, hold_cnt<=H-1.
  - hold_cnt==0 and sample_idx==N-1: a_valid<=0, done<=1, go to FIN.
- pause=1 in RUN: all registers hold, and a_changed=0.
- FIN: done=1 for exactly this cycle. Next edge goes to IDLE with done<=0. a_out keeps the last sample.
- Latency: first sample is visible the cycle after start is sampled. Each sample is visible for exactly H unpaused cycles. Run length is N*H cycles of a_valid plus 1 FIN cycle.
- a_changed: registered, equal to (new a_out != old a_out) && new a_valid. The old value includes a_out from reset or from the previous run's last sample.
- start in RUN/FIN is ignored (not queued). num_samples/hold_cycles changes during a run have no effect.
- num_samples=2^CNT_W-1 and hold_cycles=2^CNT_W-1 must work without overflow. Counters compare; they never wrap.

Decomposition:
- Package stim_gen_pkg holds:
  - state enum {IDLE,RUN,FIN}
  - LFSR_TAPS=16'hB400
  - DEFAULT_SEED=16'hACE1
  - function lfsr_next(input logic [15:0] s)
- Sub-module lfsr_galois, purely sequential. Ports: clk, rst, load, load_val, adv, state out. The top-level FSM drives load/adv.

Test Plan:
1. Reset, then start with N=6, H=1, default seed -> a_out 0,0,0,0,1,1 on cycles 1..6 (LFSR 0xE270,0x7138,0x389C,0x1C4E,0x0E27,0xB313); a_changed=1 only on cycle 5; done pulse on cycle 7; busy cycles 1..7.
2. N=3, H=4 -> each value stable 4 cycles; sample_idx 0,0,0,0,1,1,1,1,2,2,2,2; a_valid 12 cycles; done on cycle 13.
3. N=0 -> a_valid never asserts; done one cycle after start; LFSR unchanged (next run reproduces scenario 1).
4. seed_load with seed=0 together with start, N=1 -> identical to scenario 1 first sample (SEED substituted); seed=16'h0001, N=1 -> LFSR 0xB400, a_out=0.
5. N=4, H=2, pause held 3 cycles mid-sample-1; start pulsed during RUN -> a_out frozen, run stretched by 3 cycles, a_changed=0 while paused, second start ignored, single done.
6. rst asserted during RUN (N=10, H=1, cycle 4) -> next cycle all outputs 0, state IDLE, no done; restart reproduces scenario-1 sequence.
